maze_mem: RTL and testbench

Grid memory on the responder side of the solver's maze port. Holds a square maze of 2^maze_width × 2^maze_width cells, each free, wall or visited. Loaded serially after reset, then answers `maze_oe` reads and `maze_we` visited-marks from the solver. Streams the final grid out on request, so the bench and display logic can recover the path the solver wrote.

---
 rtl/maze_mem_if.sv | 26 ++
 rtl/maze_mem.sv | 181 ++++++++++++++++++
 tb/tb_maze_mem.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/maze_mem_if.sv
// rtl/maze_mem_if.sv - solver-side maze port: cell address, read/visit-mark strobes, wall read data
interface maze_mem_if #(
    parameter int maze_width = 6
);
    logic [maze_width-1:0] row;
    logic [maze_width-1:0] col;
    logic                  maze_oe;
    logic                  maze_we;
    logic                  maze_in;

    modport master (
        output row,
        output col,
        output maze_oe,
        output maze_we,
        input  maze_in
    );

    modport slave (
        input  row,
        input  col,
        input  maze_oe,
        input  maze_we,
        output maze_in
    );
endinterface

// File: rtl/maze_mem.sv
// rtl/maze_mem.sv - maze grid memory: serial load, solver read/visit port, raster dump
// Optional MAZE_WALL_PROTECT_EN: walls cannot be marked visited; bad writes/loads set sticky wall_err.
module maze_mem #(
    parameter int maze_width = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    maze_mem_if.slave             sol,
    input  logic                  load_valid,
    input  logic                  load_data,
    output logic                  load_ready,
    output logic                  ready,
    output logic [2*maze_width:0] visit_count,
    input  logic                  dump_req,
    output logic                  dump_valid,
    output logic [1:0]            dump_data,
    output logic                  dump_last
`ifdef MAZE_WALL_PROTECT_EN
    ,
    output logic                  wall_err
`endif
);

    localparam int AW    = 2 * maze_width;
    localparam int CELLS = 1 << AW;

    localparam logic [1:0] C_FREE = 2'b00;
    localparam logic [1:0] C_WALL = 2'b01;
    localparam logic [1:0] C_VIS  = 2'b10;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;

    logic [1:0]    mem_q [CELLS];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic [AW-1:0] dump_ptr_q, dump_ptr_d;
    logic          load_ready_q, load_ready_d;
    logic          ready_q, ready_d;
    logic          maze_in_q, maze_in_d;
    logic [AW:0]   visit_count_q, visit_count_d;
    logic          dump_valid_q, dump_valid_d;
    logic [1:0]    dump_data_q, dump_data_d;
    logic          dump_last_q, dump_last_d;
`ifdef MAZE_WALL_PROTECT_EN
    logic          wall_err_q, wall_err_d;
`endif

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [1:0]    mem_wdata;
    logic [AW-1:0] sol_addr;
    logic [1:0]    sol_cell;

    assign sol_addr = {sol.row, sol.col};
    assign sol_cell = mem_q[sol_addr];

    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        dump_ptr_d    = dump_ptr_q;
        load_ready_d  = (state_q == S_LOAD);
        ready_d       = ready_q | (state_q != S_LOAD);
        maze_in_d     = maze_in_q;
        visit_count_d = visit_count_q;
        dump_valid_d  = 1'b0;
        dump_data_d   = C_FREE;
        dump_last_d   = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = load_ptr_q;
        mem_wdata     = {1'b0, load_data};
`ifdef MAZE_WALL_PROTECT_EN
        wall_err_d    = wall_err_q | (load_valid & ~load_ready_q);
`endif

        case (state_q)
            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    mem_we     = 1'b1;
                    load_ptr_d = load_ptr_q + 1'b1;
                    if (load_ptr_q == {AW{1'b1}}) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Read sees the pre-write cell, so oe+we on one address returns the old value.
                if (sol.maze_oe) begin
                    maze_in_d = (sol_cell == C_WALL);
                end
                if (sol.maze_we) begin
                    if (sol_cell == C_FREE) begin
                        mem_we        = 1'b1;
                        mem_waddr     = sol_addr;
                        mem_wdata     = C_VIS;
                        visit_count_d = visit_count_q + 1'b1;
                    end else if (sol_cell == C_WALL) begin
`ifdef MAZE_WALL_PROTECT_EN
                        wall_err_d    = 1'b1;
`else
                        mem_we        = 1'b1;
                        mem_waddr     = sol_addr;
                        mem_wdata     = C_VIS;
                        visit_count_d = visit_count_q + 1'b1;
`endif
                    end
                end
                if (dump_req) begin
                    state_d    = S_DUMP;
                    dump_ptr_d = '0;
                end
            end
            S_DUMP: begin
                // One idle cycle after the last beat keeps the solver port dead until dump_last drops.
                if (dump_last_q) begin
                    state_d = S_RUN;
                end else begin
                    dump_valid_d = 1'b1;
                    dump_data_d  = mem_q[dump_ptr_q];
                    dump_ptr_d   = dump_ptr_q + 1'b1;
                    dump_last_d  = (dump_ptr_q == {AW{1'b1}});
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            load_ptr_q    <= '0;
            dump_ptr_q    <= '0;
            load_ready_q  <= 1'b0;
            ready_q       <= 1'b0;
            maze_in_q     <= 1'b1;
            visit_count_q <= '0;
            dump_valid_q  <= 1'b0;
            dump_data_q   <= C_FREE;
            dump_last_q   <= 1'b0;
`ifdef MAZE_WALL_PROTECT_EN
            wall_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            dump_ptr_q    <= dump_ptr_d;
            load_ready_q  <= load_ready_d;
            ready_q       <= ready_d;
            maze_in_q     <= maze_in_d;
            visit_count_q <= visit_count_d;
            dump_valid_q  <= dump_valid_d;
            dump_data_q   <= dump_data_d;
            dump_last_q   <= dump_last_d;
`ifdef MAZE_WALL_PROTECT_EN
            wall_err_q    <= wall_err_d;
`endif
        end
    end

    assign sol.maze_in  = maze_in_q;
    assign load_ready   = load_ready_q;
    assign ready        = ready_q;
    assign visit_count  = visit_count_q;
    assign dump_valid   = dump_valid_q;
    assign dump_data    = dump_data_q;
    assign dump_last    = dump_last_q;
`ifdef MAZE_WALL_PROTECT_EN
    assign wall_err     = wall_err_q;
`endif

endmodule

// File: tb/tb_maze_mem.sv
// tb/tb_maze_mem.sv - directed self-checking bench for maze_mem on an 8x8 bordered maze
module tb_maze_mem;

    localparam int W = 3;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_data;
    logic         load_ready;
    logic         ready;
    logic [2*W:0] visit_count;
    logic         dump_req;
    logic         dump_valid;
    logic [1:0]   dump_data;
    logic         dump_last;
`ifdef MAZE_WALL_PROTECT_EN
    logic         wall_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [1:0] expc [N*N];

    maze_mem_if #(.maze_width(W)) sol_if ();

    maze_mem #(.maze_width(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sol         (sol_if.slave),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .ready       (ready),
        .visit_count (visit_count),
        .dump_req    (dump_req),
        .dump_valid  (dump_valid),
        .dump_data   (dump_data),
        .dump_last   (dump_last)
`ifdef MAZE_WALL_PROTECT_EN
        ,
        .wall_err    (wall_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_maze_in"}, {31'd0, sol_if.maze_in}, 32'd1);
        chk({tag, "_load_ready"}, {31'd0, load_ready}, 32'd0);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
        chk({tag, "_visit_count"}, {25'd0, visit_count}, 32'd0);
        chk({tag, "_dump_valid"}, {31'd0, dump_valid}, 32'd0);
        chk({tag, "_dump_data"}, {30'd0, dump_data}, 32'd0);
        chk({tag, "_dump_last"}, {31'd0, dump_last}, 32'd0);
`ifdef MAZE_WALL_PROTECT_EN
        chk({tag, "_wall_err"}, {31'd0, wall_err}, 32'd0);
`endif
    endtask

    task automatic solver(input int r, input int c, input logic oe, input logic we);
        sol_if.row     = r[W-1:0];
        sol_if.col     = c[W-1:0];
        sol_if.maze_oe = oe;
        sol_if.maze_we = we;
    endtask

    function automatic logic is_wall(input int r, input int c);
        return (r == 0 || r == N-1 || c == 0 || c == N-1) && !(r == 0 && c == 3);
    endfunction

    initial begin
        int visits;
        int exp_count;

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 1'b0;
        dump_req   = 1'b0;
        solver(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < N*N; i++) begin
            expc[i] = is_wall(i / N, i % N) ? 2'b01 : 2'b00;
        end

        @(negedge clk);
        step();
        chk_reset_outputs("reset");

        rst = 1'b0;
        step();
        chk("load_ready_after_reset", {31'd0, load_ready}, 32'd1);
        chk("ready_before_load", {31'd0, ready}, 32'd0);

        for (int i = 0; i < N*N; i++) begin
            load_valid = 1'b1;
            load_data  = expc[i][0];
            step();
        end
        load_valid = 1'b0;
        chk("ready_at_last_beat", {31'd0, ready}, 32'd0);
        step();
        chk("ready_after_load", {31'd0, ready}, 32'd1);
        chk("load_ready_after_load", {31'd0, load_ready}, 32'd0);

        solver(0, 0, 1'b1, 1'b0);
        step();
        chk("read_wall_0_0", {31'd0, sol_if.maze_in}, 32'd1);
        solver(0, 3, 1'b1, 1'b0);
        step();
        chk("read_gap_0_3", {31'd0, sol_if.maze_in}, 32'd0);
        solver(0, 0, 1'b0, 1'b0);
        step();
        chk("maze_in_holds", {31'd0, sol_if.maze_in}, 32'd0);

        exp_count = 0;
        solver(2, 2, 1'b0, 1'b1);
        step();
        exp_count++;
        expc[2*N+2] = 2'b10;
        chk("count_first_visit", {25'd0, visit_count}, exp_count);
        step();
        chk("count_revisit", {25'd0, visit_count}, exp_count);
        solver(2, 2, 1'b1, 1'b0);
        step();
        chk("read_visited_2_2", {31'd0, sol_if.maze_in}, 32'd0);

        solver(0, 0, 1'b1, 1'b0);
        step();
        chk("read_wall_again", {31'd0, sol_if.maze_in}, 32'd1);
        solver(3, 4, 1'b1, 1'b1);
        step();
        exp_count++;
        expc[3*N+4] = 2'b10;
        chk("oe_we_same_addr", {31'd0, sol_if.maze_in}, 32'd0);
        chk("count_oe_we", {25'd0, visit_count}, exp_count);
        solver(3, 4, 1'b1, 1'b0);
        step();
        chk("read_after_oe_we", {31'd0, sol_if.maze_in}, 32'd0);

        // Third visit coincides with the dump request; the write must land first.
        solver(5, 5, 1'b0, 1'b1);
        dump_req = 1'b1;
        step();
        exp_count++;
        expc[5*N+5] = 2'b10;
        chk("count_with_dump_req", {25'd0, visit_count}, exp_count);
        chk("no_beat_yet", {31'd0, dump_valid}, 32'd0);
        solver(6, 6, 1'b1, 1'b1);
        sol_if.row = 3'd0;
        sol_if.col = 3'd0;
        step();
        visits = 0;
        for (int i = 0; i < N*N; i++) begin
            chk($sformatf("dump_valid_%0d", i), {31'd0, dump_valid}, 32'd1);
            chk($sformatf("dump_data_%0d", i), {30'd0, dump_data}, {30'd0, expc[i]});
            chk($sformatf("dump_last_%0d", i), {31'd0, dump_last}, (i == N*N-1) ? 32'd1 : 32'd0);
            if (dump_data == 2'b10) visits++;
            step();
        end
        solver(0, 0, 1'b0, 1'b0);
        dump_req = 1'b0;
        chk("dump_visit_codes", visits, 32'd3);
        chk("dump_ends", {31'd0, dump_valid}, 32'd0);
        chk("dump_ignored_oe", {31'd0, sol_if.maze_in}, 32'd0);
        chk("dump_ignored_we", {25'd0, visit_count}, exp_count);
        chk("ready_after_dump", {31'd0, ready}, 32'd1);

        solver(0, 0, 1'b0, 1'b1);
        step();
        solver(0, 0, 1'b1, 1'b0);
`ifdef MAZE_WALL_PROTECT_EN
        chk("wall_write_count", {25'd0, visit_count}, exp_count);
        chk("wall_err_set", {31'd0, wall_err}, 32'd1);
        step();
        chk("wall_still_wall", {31'd0, sol_if.maze_in}, 32'd1);
`else
        exp_count++;
        expc[0] = 2'b10;
        chk("wall_write_count", {25'd0, visit_count}, exp_count);
        step();
        chk("wall_overwritten", {31'd0, sol_if.maze_in}, 32'd0);
`endif
        solver(0, 0, 1'b0, 1'b0);

        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("beat20_valid", {31'd0, dump_valid}, 32'd1);
        chk("beat20_data", {30'd0, dump_data}, {30'd0, expc[19]});
        rst = 1'b1;
        step();
        chk_reset_outputs("mid_dump_reset");
        rst = 1'b0;
        step();
        chk("load_ready_after_rerst", {31'd0, load_ready}, 32'd1);
        chk("ready_after_rerst", {31'd0, ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
